// File: rtl/xgmii_rx_deframer_if.sv
// xgmii_rx_deframer_if: XGMII receive word bus in, AXI-Stream payload bus out.
interface xgmii_rx_deframer_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0]   i_xgmii_rxd;
  logic [DATA_WIDTH/8-1:0] i_xgmii_rxc;
  logic                    i_xgmii_valid;
  logic [DATA_WIDTH/8-1:0] i_term_loc;
  logic [DATA_WIDTH-1:0]   o_axis_tdata;
  logic [DATA_WIDTH/8-1:0] o_axis_tkeep;
  logic                    o_axis_tvalid;
  logic                    o_axis_tlast;
  logic                    o_axis_tuser;
  logic                    o_frame_err;
  modport master (
    output i_xgmii_rxd, i_xgmii_rxc, i_xgmii_valid, i_term_loc,
    input  o_axis_tdata, o_axis_tkeep, o_axis_tvalid, o_axis_tlast, o_axis_tuser, o_frame_err
  );
  modport slave (
    input  i_xgmii_rxd, i_xgmii_rxc, i_xgmii_valid, i_term_loc,
    output o_axis_tdata, o_axis_tkeep, o_axis_tvalid, o_axis_tlast, o_axis_tuser, o_frame_err
  );
endinterface

// File: rtl/xgmii_rx_deframer.sv
// xgmii_rx_deframer: strips preamble/SFD/FCS from 32-bit XGMII words, emits AXI-Stream with error on tlast.
// Define XGMII_RX_CRC_CHECK_EN to include the CRC-32 check.
module xgmii_rx_deframer #(
  parameter int DATA_WIDTH      = 32,
  parameter int MIN_FRAME_BYTES = 64
) (
  input logic               i_clk,
  input logic               i_reset_n,
  xgmii_rx_deframer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, FLUSH} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, tdata_q, tdata_d;
  logic [1:0]            fill_q, fill_d, k_q, k_d;
  logic                  err_q, err_d, ferr_q, ferr_d;
  logic [15:0]           bytes_q, bytes_d;
  logic [3:0]            tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d, frame_err_q, frame_err_d;
  logic                  v, start, sfd, term, runt, crc_bad, bad;
  logic [1:0]            k;
  assign v     = bus.i_xgmii_valid;
  assign start = v && bus.i_xgmii_rxc == 4'b0001 && bus.i_xgmii_rxd == 32'h555555FB;
  assign sfd   = bus.i_xgmii_rxc == 4'b0000 && bus.i_xgmii_rxd == 32'hD5555555;
  assign term  = |bus.i_term_loc;
  assign k     = bus.i_term_loc[3] ? 2'd3 : bus.i_term_loc[2] ? 2'd2 : bus.i_term_loc[1] ? 2'd1 : 2'd0;
  assign runt  = ({1'b0, bytes_q} + {15'd0, k}) < 17'(MIN_FRAME_BYTES);
  assign bad   = err_q | runt | crc_bad;
`ifdef XGMII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_n, crc_rev;
  function automatic logic [31:0] crc_bytes(input logic [31:0] c_in, input logic [31:0] w, input logic [2:0] n);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 4; i++)
      if (3'(i) < n) begin
        c = c ^ {24'h0, w[8*i +: 8]};
        for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
      end
    return c;
  endfunction
  assign crc_n   = crc_bytes(crc_q, bus.i_xgmii_rxd, term ? {1'b0, k} : 3'd4);
  // the residue constant is quoted in MSB-first order, the register is LSB-first
  assign crc_rev = {<<{crc_n}};
  assign crc_bad = crc_rev != 32'hC704DD7B;
  always_comb crc_d = (state_q == PREAMBLE && v && sfd) ? 32'hFFFFFFFF : (state_q == DATA && v) ? crc_n : crc_q;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) crc_q <= 32'hFFFFFFFF;
    else crc_q <= crc_d;
`else
  assign crc_bad = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    fill_d   = fill_q;
    k_d      = k_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    bytes_d  = bytes_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    tuser_d  = 1'b0;
    unique case (state_q)
      IDLE: state_d = start ? PREAMBLE : IDLE;
      PREAMBLE: if (v) begin
        state_d = sfd ? DATA : IDLE;
        fill_d  = 2'd0;
        err_d   = 1'b0;
        bytes_d = 16'd0;
      end
      DATA: if (v && !term) begin
        tvalid_d = fill_q == 2'd2;
        tdata_d  = fill_q == 2'd2 ? s2_q : tdata_q;
        tkeep_d  = fill_q == 2'd2 ? 4'hF : tkeep_q;
        s2_d     = s1_q;
        s1_d     = bus.i_xgmii_rxd;
        fill_d   = fill_q == 2'd2 ? 2'd2 : fill_q + 2'd1;
        err_d    = err_q | (|bus.i_xgmii_rxc);
        bytes_d  = bytes_q > 16'hFFFB ? 16'hFFFF : bytes_q + 16'd4;
      end else if (v) begin
        // fill 2 emits s2 now (s1 later in FLUSH unless it is all FCS); fill 1 is a truncated frame
        k_d      = k;
        ferr_d   = bad;
        state_d  = (fill_q == 2'd2 && k != 2'd0) ? FLUSH : IDLE;
        tvalid_d = fill_q != 2'd0;
        tdata_d  = fill_q == 2'd2 ? s2_q : fill_q == 2'd1 ? s1_q : tdata_q;
        tkeep_d  = fill_q != 2'd0 ? 4'hF : tkeep_q;
        tlast_d  = fill_q == 2'd1 || (fill_q == 2'd2 && k == 2'd0);
        tuser_d  = fill_q == 2'd1 || (fill_q == 2'd2 && k == 2'd0 && bad);
      end
      FLUSH: begin
        state_d  = start ? PREAMBLE : IDLE;
        tvalid_d = 1'b1;
        tdata_d  = s1_q;
        tkeep_d  = (4'b0001 << k_q) - 4'd1;
        tlast_d  = 1'b1;
        tuser_d  = ferr_q;
      end
    endcase
    frame_err_d = tlast_d & tuser_d;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q     <= IDLE;
      s1_q        <= '0;
      s2_q        <= '0;
      fill_q      <= 2'd0;
      k_q         <= 2'd0;
      err_q       <= 1'b0;
      ferr_q      <= 1'b0;
      bytes_q     <= 16'd0;
      tdata_q     <= '0;
      tkeep_q     <= 4'h0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      fill_q      <= fill_d;
      k_q         <= k_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      bytes_q     <= bytes_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      frame_err_q <= frame_err_d;
    end
  assign bus.o_axis_tdata  = tdata_q;
  assign bus.o_axis_tkeep  = tkeep_q;
  assign bus.o_axis_tvalid = tvalid_q;
  assign bus.o_axis_tlast  = tlast_q;
  assign bus.o_axis_tuser  = tuser_q;
  assign bus.o_frame_err   = frame_err_q;
endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// tb_xgmii_rx_deframer: directed plus random frames checked against a byte-level frame model.
module tb_xgmii_rx_deframer;
`ifdef XGMII_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last, user, ferr;
    int          cyc;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b1;
  int   checks = 0, errors = 0, cyc = 0, stray = 0;
  beat_t got_q[$], exp_q[$];
  always #5 clk = ~clk;
  xgmii_rx_deframer_if ifc ();
  xgmii_rx_deframer #(.DATA_WIDTH(32), .MIN_FRAME_BYTES(64)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(ifc.slave));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (ifc.o_axis_tvalid)
      got_q.push_back('{ifc.o_axis_tdata, ifc.o_axis_tkeep, ifc.o_axis_tlast, ifc.o_axis_tuser, ifc.o_frame_err, cyc});
    else if (ifc.o_frame_err) stray++;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      repeat (8) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
    end
    return ~c;
  endfunction
  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{k[j]}};
    return m;
  endfunction
  task automatic put(input logic [31:0] d, input logic [3:0] c, input logic [3:0] t, input logic v);
    ifc.i_xgmii_rxd   = d;
    ifc.i_xgmii_rxc   = c;
    ifc.i_term_loc    = t;
    ifc.i_xgmii_valid = v;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) put(32'h07070707, 4'hF, 4'h0, 1'b1);
  endtask
  task automatic gput(input logic [31:0] d, input logic [3:0] c, input logic [3:0] t, input int gap);
    if (gap > 0 && cyc % gap == gap - 1) put($urandom, 4'($urandom), 4'($urandom), 1'b0);
    put(d, c, t, 1'b1);
  endtask
  task automatic build(input int plen, input bit incr, input bit bad_fcs, output logic [7:0] fr[$]);
    logic [31:0] f;
    fr = {};
    for (int i = 0; i < plen; i++) fr.push_back(incr ? 8'(i) : 8'($urandom));
    f = crc32(fr);
    for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
    if (bad_fcs) fr[plen] = fr[plen] ^ 8'h01;
  endtask
  task automatic send_frame(input logic [7:0] fr[$], input bit bad_sfd, input int gap, input int ctl_word, output int term_cyc);
    int n, w, k;
    logic [31:0] tw;
    logic [3:0] tc;
    n = fr.size(); w = n / 4; k = n % 4;
    put(32'h555555FB, 4'b0001, 4'h0, 1'b1);
    gput(bad_sfd ? 32'hD5555554 : 32'hD5555555, 4'h0, 4'h0, gap);
    for (int i = 0; i < w; i++)
      gput({fr[4*i+3], fr[4*i+2], fr[4*i+1], fr[4*i]}, i == ctl_word ? 4'b0100 : 4'b0000, 4'h0, gap);
    tw = 32'h07070707; tc = 4'hF;
    for (int j = 0; j < k; j++) begin
      tw[8*j +: 8] = fr[4*w+j];
      tc[j] = 1'b0;
    end
    tw[8*k +: 8] = 8'hFD;
    gput(tw, tc, 4'(1 << k), gap);
    term_cyc = cyc;
  endtask
  task automatic expect_frame(input logic [7:0] fr[$], input bit ctl, input int term_cyc);
    logic [7:0] pl[$];
    int p;
    bit bad;
    beat_t e;
    pl = fr;
    repeat (4) void'(pl.pop_back());
    p = pl.size();
    bad = ctl || fr.size() < 64 || (CRC_ON && crc32(pl) != {fr[p+3], fr[p+2], fr[p+1], fr[p]});
    for (int i = 0; i < p; i += 4) begin
      e.data = '0; e.keep = '0;
      for (int j = 0; j < 4 && i + j < p; j++) begin
        e.data[8*j +: 8] = pl[i+j];
        e.keep[j] = 1'b1;
      end
      e.last = i + 4 >= p;
      e.user = e.last && bad;
      e.ferr = e.user;
      e.cyc  = term_cyc + 2;
      exp_q.push_back(e);
    end
  endtask
  task automatic drain(input string tag);
    beat_t g, e;
    idle(4);
    chk({tag, " beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size()) begin
        g = got_q[i]; e = exp_q[i];
        chk($sformatf("%s beat%0d", tag, i), {g.data & kmask(e.keep), g.keep, g.last, g.last & g.user, g.ferr},
            {e.data, e.keep, e.last, e.user, e.ferr});
        if (e.last) chk({tag, " last latency ok"}, 64'(g.cyc <= e.cyc), 64'd1);
      end
    chk({tag, " stray frame_err"}, 64'(stray), 64'd0);
    got_q.delete(); exp_q.delete();
  endtask
  initial begin
    logic [7:0] fr[$], fr2[$];
    int tc, tc2, plen, cw, gap;
    bit bf;
    beat_t e;
    ifc.i_xgmii_rxd = 32'h07070707; ifc.i_xgmii_rxc = 4'hF; ifc.i_term_loc = 4'h0; ifc.i_xgmii_valid = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset tvalid", 64'(ifc.o_axis_tvalid), 64'd0);
    chk("reset outputs", {ifc.o_axis_tdata, ifc.o_axis_tkeep, ifc.o_axis_tlast, ifc.o_axis_tuser, ifc.o_frame_err}, 64'd0);
    rst_n = 1'b1;
    idle(3);
    build(60, 1, 0, fr); send_frame(fr, 0, 0, -1, tc); expect_frame(fr, 0, tc); drain("f64");
    build(61, 1, 0, fr); send_frame(fr, 0, 0, -1, tc); expect_frame(fr, 0, tc); drain("f65");
    build(60, 1, 1, fr); send_frame(fr, 0, 0, -1, tc); expect_frame(fr, 0, tc); drain("badfcs");
    build(28, 1, 0, fr); send_frame(fr, 0, 0, -1, tc); expect_frame(fr, 0, tc); drain("runt32");
    build(60, 1, 0, fr); send_frame(fr, 1, 0, -1, tc); drain("badsfd");
    build(61, 1, 0, fr); build(60, 0, 0, fr2);
    send_frame(fr, 0, 33, -1, tc); send_frame(fr2, 0, 33, -1, tc2);
    expect_frame(fr, 0, tc); expect_frame(fr2, 0, tc2); drain("b2b");
    build(60, 1, 0, fr);
    put(32'h555555FB, 4'b0001, 4'h0, 1'b1);
    put(32'hD5555555, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 7; i++) put({fr[4*i+3], fr[4*i+2], fr[4*i+1], fr[4*i]}, 4'h0, 4'h0, 1'b1);
    ifc.i_xgmii_rxd = {fr[31], fr[30], fr[29], fr[28]};
    #2 rst_n = 1'b0;
    #1 chk("midreset tvalid", 64'(ifc.o_axis_tvalid), 64'd0);
    chk("midreset tlast", 64'(ifc.o_axis_tlast), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e.data = {fr[4*i+3], fr[4*i+2], fr[4*i+1], fr[4*i]}; e.keep = 4'hF;
      e.last = 1'b0; e.user = 1'b0; e.ferr = 1'b0; e.cyc = 0;
      exp_q.push_back(e);
    end
    drain("midreset");
    build(60, 0, 0, fr); send_frame(fr, 0, 0, -1, tc); expect_frame(fr, 0, tc); drain("postreset");
    for (int t = 0; t < 12; t++) begin
      plen = $urandom_range(8, 100);
      bf   = $urandom_range(0, 3) == 0;
      cw   = $urandom_range(0, 5) == 0 ? int'($urandom_range(0, (plen + 4) / 4 - 1)) : -1;
      gap  = $urandom_range(0, 1) ? int'($urandom_range(5, 33)) : 0;
      build(plen, 0, bf, fr); send_frame(fr, 0, gap, cw, tc); expect_frame(fr, cw >= 0, tc);
      drain($sformatf("rnd%0d", t));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
